// File: rtl/clip_sequencer.sv
// ---------------------------------------------------------------------------
// clip_sequencer
//
// Record/playback controller for audio clips held in a shared sample memory.
// Each clip slot owns 2^OFFSET_W consecutive samples at address
// {clip, offset}. One memory request is issued per accepted sample tick, and
// a recorded length is kept per slot. The selected and playing clip numbers
// are driven out as single hex digits for the seven-segment display block.
//
// Optional feature macro: CLIP_LOOP_EN
//   defined   : playback wraps to the start of the clip at end of clip and
//               keeps playing until play_i is pulsed again.
//   undefined : playback returns to IDLE after the final sample of the clip.
//
// Ports:
//   clock_i        system clock
//   reset_i        synchronous, active-low reset
//   sel_next_i     pulse: advance clip selection (IDLE only)
//   record_i       pulse: start/stop recording
//   play_i         pulse: start/stop playback
//   sample_tick_i  sample-rate strobe
//   sample_i       input sample, valid with sample_tick_i
//   mem_req_o      memory request, held until mem_ack_i
//   mem_we_o       1 = write, 0 = read
//   mem_addr_o     request address {clip, offset}
//   mem_wdata_o    write data
//   mem_rdata_i    read data, valid with mem_ack_i
//   mem_ack_i      request complete
//   sample_o       playback sample
//   sample_valid_o one-cycle strobe for sample_o
//   play_clip_o    clip being played, 4'hF = blank
//   record_clip_o  selected/recording clip, 4'hF = blank
//   overrun_o      sticky: a sample tick was dropped
// ---------------------------------------------------------------------------
module clip_sequencer #(
    parameter int NUM_CLIPS = 5,
    parameter int OFFSET_W  = 14,
    parameter int SAMPLE_W  = 8,
    localparam int CLIP_W   = $clog2(NUM_CLIPS),
    localparam int ADDR_W   = CLIP_W + OFFSET_W
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                sel_next_i,
    input  logic                record_i,
    input  logic                play_i,
    input  logic                sample_tick_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [SAMPLE_W-1:0] mem_wdata_o,
    input  logic [SAMPLE_W-1:0] mem_rdata_i,
    input  logic                mem_ack_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_valid_o,
    output logic [3:0]          play_clip_o,
    output logic [3:0]          record_clip_o,
    output logic                overrun_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Zero-extend a clip index to a display digit.
    function automatic logic [3:0] to_digit(input logic [CLIP_W-1:0] clip);
        logic [3:0] digit;
        digit = 4'd0;
        digit[CLIP_W-1:0] = clip;
        return digit;
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic [CLIP_W-1:0]     sel_r;
    logic [CLIP_W-1:0]     sel_s;
    logic [OFFSET_W-1:0]   offset_r;
    logic [OFFSET_W-1:0]   offset_s;
    logic [OFFSET_W:0]     len_r [NUM_CLIPS];
    logic [OFFSET_W:0]     len_s [NUM_CLIPS];
    logic                  stop_pending_r;
    logic                  stop_pending_s;
    logic                  req_r;
    logic                  req_s;
    logic                  we_r;
    logic                  we_s;
    logic [ADDR_W-1:0]     addr_r;
    logic [ADDR_W-1:0]     addr_s;
    logic [SAMPLE_W-1:0]   wdata_r;
    logic [SAMPLE_W-1:0]   wdata_s;
    logic [SAMPLE_W-1:0]   sample_r;
    logic [SAMPLE_W-1:0]   sample_s;
    logic                  valid_r;
    logic                  valid_s;
    logic                  overrun_r;
    logic                  overrun_s;
    logic [3:0]            play_clip_r;
    logic [3:0]            play_clip_s;
    logic [3:0]            record_clip_r;
    logic [3:0]            record_clip_s;

    logic                  ack_s;
    logic                  stop_s;
    logic                  play_ok_s;
    logic                  slot_full_s;
    logic                  clip_end_s;
    logic [OFFSET_W:0]     offset_inc_s;
    logic [OFFSET_W:0]     cur_len_s;

    // An ack only counts while our request is actually outstanding.
    assign ack_s        = req_r & mem_ack_i;
    // The button that started the current activity also stops it.
    assign stop_s       = (state_r == ST_RECORD) ? record_i :
                          ((state_r == ST_PLAY) ? play_i : 1'b0);
    assign cur_len_s    = len_r[sel_r];
    assign play_ok_s    = (cur_len_s != {(OFFSET_W+1){1'b0}});
    assign offset_inc_s = {1'b0, offset_r} + {{OFFSET_W{1'b0}}, 1'b1};
    assign slot_full_s  = (offset_r == {OFFSET_W{1'b1}});
    assign clip_end_s   = (offset_inc_s == cur_len_s);

    // Next-state and next-output computation for the record/play sequencer.
    always_comb begin
        state_s        = state_r;
        sel_s          = sel_r;
        offset_s       = offset_r;
        len_s          = len_r;
        stop_pending_s = stop_pending_r;
        req_s          = req_r;
        we_s           = we_r;
        addr_s         = addr_r;
        wdata_s        = wdata_r;
        sample_s       = sample_r;
        valid_s        = 1'b0;
        overrun_s      = overrun_r;

        case (state_r)
            ST_IDLE: begin
                // Ticks are ignored here, including one that coincides with
                // a start pulse; a start pulse also swallows sel_next_i.
                if (record_i) begin
                    state_s         = ST_RECORD;
                    offset_s        = {OFFSET_W{1'b0}};
                    len_s[sel_r]    = {(OFFSET_W+1){1'b0}};
                end else if (play_i && play_ok_s) begin
                    state_s         = ST_PLAY;
                    offset_s        = {OFFSET_W{1'b0}};
                end else if (sel_next_i) begin
                    if (sel_r == CLIP_W'(NUM_CLIPS - 1)) begin
                        sel_s = {CLIP_W{1'b0}};
                    end else begin
                        sel_s = sel_r + CLIP_W'(1'b1);
                    end
                end else begin
                    sel_s = sel_r;
                end
            end

            ST_RECORD, ST_PLAY: begin
                if (ack_s) begin
                    req_s    = 1'b0;
                    offset_s = offset_inc_s[OFFSET_W-1:0];
                    // The ack cycle still has the request outstanding.
                    if (sample_tick_i) begin
                        overrun_s = 1'b1;
                    end else begin
                        overrun_s = overrun_r;
                    end
                    if (state_r == ST_RECORD) begin
                        len_s[sel_r] = offset_inc_s;
                        if (slot_full_s) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = state_r;
                        end
                    end else begin
                        sample_s = mem_rdata_i;
                        valid_s  = 1'b1;
                        if (clip_end_s) begin
`ifdef CLIP_LOOP_EN
                            offset_s = {OFFSET_W{1'b0}};
`else
                            state_s  = ST_IDLE;
`endif
                        end else begin
                            state_s = state_r;
                        end
                    end
                    // A stop waiting on this ack (or arriving with it) wins
                    // after the ack has taken its normal effect.
                    if (stop_pending_r || stop_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        stop_pending_s = stop_pending_r;
                    end
                end else if (stop_s) begin
                    if (req_r) begin
                        stop_pending_s = 1'b1;
                        if (sample_tick_i) begin
                            overrun_s = 1'b1;
                        end else begin
                            overrun_s = overrun_r;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (sample_tick_i) begin
                    if (req_r) begin
                        overrun_s = 1'b1;
                    end else begin
                        req_s   = 1'b1;
                        we_s    = (state_r == ST_RECORD);
                        addr_s  = {sel_r, offset_r};
                        wdata_s = sample_i;
                    end
                end else begin
                    req_s = req_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
            end
        endcase

        if (state_s == ST_IDLE) begin
            stop_pending_s = 1'b0;
        end else begin
            stop_pending_s = stop_pending_s;
        end

        if (state_s == ST_PLAY) begin
            play_clip_s   = to_digit(sel_s);
            record_clip_s = DIGIT_BLANK;
        end else begin
            play_clip_s   = DIGIT_BLANK;
            record_clip_s = to_digit(sel_s);
        end
    end

    // State, slot lengths and registered outputs.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_r        <= ST_IDLE;
            sel_r          <= {CLIP_W{1'b0}};
            offset_r       <= {OFFSET_W{1'b0}};
            for (int i = 0; i < NUM_CLIPS; i++) begin
                len_r[i] <= {(OFFSET_W+1){1'b0}};
            end
            stop_pending_r <= 1'b0;
            req_r          <= 1'b0;
            we_r           <= 1'b0;
            addr_r         <= {ADDR_W{1'b0}};
            wdata_r        <= {SAMPLE_W{1'b0}};
            sample_r       <= {SAMPLE_W{1'b0}};
            valid_r        <= 1'b0;
            overrun_r      <= 1'b0;
            play_clip_r    <= DIGIT_BLANK;
            record_clip_r  <= 4'd0;
        end else begin
            state_r        <= state_s;
            sel_r          <= sel_s;
            offset_r       <= offset_s;
            len_r          <= len_s;
            stop_pending_r <= stop_pending_s;
            req_r          <= req_s;
            we_r           <= we_s;
            addr_r         <= addr_s;
            wdata_r        <= wdata_s;
            sample_r       <= sample_s;
            valid_r        <= valid_s;
            overrun_r      <= overrun_s;
            play_clip_r    <= play_clip_s;
            record_clip_r  <= record_clip_s;
        end
    end

    assign mem_req_o      = req_r;
    assign mem_we_o       = we_r;
    assign mem_addr_o     = addr_r;
    assign mem_wdata_o    = wdata_r;
    assign sample_o       = sample_r;
    assign sample_valid_o = valid_r;
    assign overrun_o      = overrun_r;
    assign play_clip_o    = play_clip_r;
    assign record_clip_o  = record_clip_r;

endmodule
